// File: rtl/gpr_bank.sv
// Mini SRC register bank: two combinational read ports, a bus write port, a load-return port and a load scoreboard.
// Define GPR_BYPASS_EN to forward same-cycle write data onto the read ports.
module gpr_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [AW-1:0]     ra,
    input  logic [AW-1:0]     rb,
    input  logic              baout,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              ld_issue,
    input  logic [AW-1:0]     ld_dst,
    output logic              ld_issue_rdy,
    input  logic              ld_ret_valid,
    input  logic [AW-1:0]     ld_ret_dst,
    input  logic [DATA_W-1:0] ld_ret_data,
    output logic              stall,
    output logic [AW:0]       ld_pending,
    output logic              wr_conflict
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_eff;
    logic                issue_acc;
    logic                pend_inc;
    logic                pend_dec;
    logic                a_zeroed;

    assign issue_acc    = ld_issue & ~busy[ld_dst];
    assign ld_issue_rdy = issue_acc;
    assign a_zeroed     = baout & (ra == '0);

    // An accepted issue and a return to the same register cancel in the counter.
    assign pend_inc = issue_acc;
    assign pend_dec = ld_ret_valid & (busy[ld_ret_dst] | (issue_acc & (ld_ret_dst == ld_dst)));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (ld_ret_valid) begin
            regs[ld_ret_dst] <= ld_ret_data;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            busy        <= '0;
            ld_pending  <= '0;
            wr_conflict <= 1'b0;
        end else begin
            if (issue_acc) begin
                busy[ld_dst] <= 1'b1;
            end
            if (ld_ret_valid && !(issue_acc && (ld_ret_dst == ld_dst))) begin
                busy[ld_ret_dst] <= 1'b0;
            end
            if (pend_inc && !pend_dec) begin
                ld_pending <= ld_pending + (AW+1)'(1);
            end else if (!pend_inc && pend_dec && (ld_pending != '0)) begin
                ld_pending <= ld_pending - (AW+1)'(1);
            end
            if (we && ld_ret_valid && (wa == ld_ret_dst)) begin
                wr_conflict <= 1'b1;
            end
        end
    end

`ifdef GPR_BYPASS_EN
    always_comb begin
        busy_eff = busy;
        if (ld_ret_valid) begin
            busy_eff[ld_ret_dst] = 1'b0;
        end
    end

    // Load return outranks the bus write, and base-address zeroing outranks both.
    always_comb begin
        rd_a = regs[ra];
        if (a_zeroed) begin
            rd_a = '0;
        end else if (ld_ret_valid && (ld_ret_dst == ra)) begin
            rd_a = ld_ret_data;
        end else if (we && (wa == ra)) begin
            rd_a = wd;
        end
    end

    always_comb begin
        rd_b = regs[rb];
        if (ld_ret_valid && (ld_ret_dst == rb)) begin
            rd_b = ld_ret_data;
        end else if (we && (wa == rb)) begin
            rd_b = wd;
        end
    end
`else
    assign busy_eff = busy;
    assign rd_a     = a_zeroed ? '0 : regs[ra];
    assign rd_b     = regs[rb];
`endif

    assign stall = (busy_eff[ra] & ~a_zeroed) | busy_eff[rb] | (we & busy_eff[wa]);

endmodule

// File: tb/tb_gpr_bank.sv
// Directed self-checking bench for gpr_bank with hand-computed expectations.
// Expectations for the same-cycle write test follow GPR_BYPASS_EN.
module tb_gpr_bank;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int AW       = 4;

    logic              clk;
    logic              clr;
    logic [AW-1:0]     ra;
    logic [AW-1:0]     rb;
    logic              baout;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DATA_W-1:0] wd;
    logic              ld_issue;
    logic [AW-1:0]     ld_dst;
    logic              ld_issue_rdy;
    logic              ld_ret_valid;
    logic [AW-1:0]     ld_ret_dst;
    logic [DATA_W-1:0] ld_ret_data;
    logic              stall;
    logic [AW:0]       ld_pending;
    logic              wr_conflict;

    int passCount;
    int totalCount;

    gpr_bank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .clr(clr), .ra(ra), .rb(rb), .baout(baout),
        .rd_a(rd_a), .rd_b(rd_b), .we(we), .wa(wa), .wd(wd),
        .ld_issue(ld_issue), .ld_dst(ld_dst), .ld_issue_rdy(ld_issue_rdy),
        .ld_ret_valid(ld_ret_valid), .ld_ret_dst(ld_ret_dst), .ld_ret_data(ld_ret_data),
        .stall(stall), .ld_pending(ld_pending), .wr_conflict(wr_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearControls();
        we = 1'b0;
        ld_issue = 1'b0;
        ld_ret_valid = 1'b0;
        #1;
    endtask

    initial begin
        passCount = 0;
        totalCount = 0;
        clr = 1'b0;
        ra = '0; rb = '0; baout = 1'b0;
        we = 1'b0; wa = '0; wd = '0;
        ld_issue = 1'b0; ld_dst = '0;
        ld_ret_valid = 1'b0; ld_ret_dst = '0; ld_ret_data = '0;

        repeat (2) applyStimulus();
        checkOutput("reset_rd_a", 64'(rd_a), 64'h0);
        checkOutput("reset_pending", 64'(ld_pending), 64'h0);
        checkOutput("reset_stall", 64'(stall), 64'h0);
        checkOutput("reset_conflict", 64'(wr_conflict), 64'h0);
        clr = 1'b1;
        applyStimulus();

        // R0 base-address rule
        we = 1'b1; wa = 4'd0; wd = 32'h0000_1234;
        applyStimulus();
        clearControls();
        ra = 4'd0; rb = 4'd0; baout = 1'b1; #1;
        checkOutput("r0_baout_rd_a", 64'(rd_a), 64'h0);
        checkOutput("r0_baout_rd_b", 64'(rd_b), 64'h1234);
        baout = 1'b0; #1;
        checkOutput("r0_plain_rd_a", 64'(rd_a), 64'h1234);
        checkOutput("r0_plain_rd_b", 64'(rd_b), 64'h1234);

        // Scoreboard on R5
        ld_issue = 1'b1; ld_dst = 4'd5; #1;
        checkOutput("issue5_rdy", 64'(ld_issue_rdy), 64'h1);
        applyStimulus();
        checkOutput("issue5_again_rdy", 64'(ld_issue_rdy), 64'h0);
        ld_issue = 1'b0; ra = 4'd5; #1;
        checkOutput("issue5_pending", 64'(ld_pending), 64'h1);
        checkOutput("issue5_stall", 64'(stall), 64'h1);
        ld_ret_valid = 1'b1; ld_ret_dst = 4'd5; ld_ret_data = 32'hDEAD_BEEF;
        applyStimulus();
        clearControls();
        checkOutput("ret5_rd_a", 64'(rd_a), 64'hDEAD_BEEF);
        checkOutput("ret5_stall", 64'(stall), 64'h0);
        checkOutput("ret5_pending", 64'(ld_pending), 64'h0);

        // Same-cycle issue and return to R7
        ld_issue = 1'b1; ld_dst = 4'd7;
        ld_ret_valid = 1'b1; ld_ret_dst = 4'd7; ld_ret_data = 32'h55;
        applyStimulus();
        clearControls();
        ra = 4'd7; #1;
        checkOutput("r7_pending", 64'(ld_pending), 64'h0);
        checkOutput("r7_rd_a", 64'(rd_a), 64'h55);
        checkOutput("r7_busy_stall", 64'(stall), 64'h1);
        ld_ret_valid = 1'b1; ld_ret_dst = 4'd7; ld_ret_data = 32'h56;
        applyStimulus();
        clearControls();
        checkOutput("r7_clear_stall", 64'(stall), 64'h0);
        checkOutput("r7_no_underflow", 64'(ld_pending), 64'h0);

        // Bus write and load return collide on R2
        we = 1'b1; wa = 4'd2; wd = 32'h11;
        ld_ret_valid = 1'b1; ld_ret_dst = 4'd2; ld_ret_data = 32'h22;
        applyStimulus();
        clearControls();
        ra = 4'd2; #1;
        checkOutput("r2_load_wins", 64'(rd_a), 64'h22);
        checkOutput("r2_conflict", 64'(wr_conflict), 64'h1);
        repeat (3) applyStimulus();
        checkOutput("r2_conflict_sticky", 64'(wr_conflict), 64'h1);

        // Fill every register with an outstanding load, then drain
        ra = 4'd0; rb = 4'd0; baout = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            ld_issue = 1'b1; ld_dst = AW'(i); #1;
            checkOutput($sformatf("fill_rdy_%0d", i), 64'(ld_issue_rdy), 64'h1);
            applyStimulus();
        end
        ld_issue = 1'b0; #1;
        checkOutput("fill_pending", 64'(ld_pending), 64'd16);
        for (int i = 0; i < NUM_REGS; i++) begin
            ld_ret_valid = 1'b1; ld_ret_dst = AW'(i); ld_ret_data = 32'(i * 256);
            applyStimulus();
        end
        clearControls();
        checkOutput("drain_pending", 64'(ld_pending), 64'd0);
        ld_ret_valid = 1'b1; ld_ret_dst = 4'd3; ld_ret_data = 32'h333;
        applyStimulus();
        clearControls();
        checkOutput("spurious_pending", 64'(ld_pending), 64'd0);
        baout = 1'b0; ra = 4'd3; #1;
        checkOutput("spurious_data", 64'(rd_a), 64'h333);

        // Same-cycle write visibility on R9
        ra = 4'd9; we = 1'b1; wa = 4'd9; wd = 32'hA5A5_A5A5; #1;
`ifdef GPR_BYPASS_EN
        checkOutput("r9_same_cycle", 64'(rd_a), 64'hA5A5_A5A5);
`else
        checkOutput("r9_same_cycle", 64'(rd_a), 64'h900);
`endif
        applyStimulus();
        clearControls();
        checkOutput("r9_next_cycle", 64'(rd_a), 64'hA5A5_A5A5);

        // Reset in the middle of a load to R3
        ld_issue = 1'b1; ld_dst = 4'd3;
        applyStimulus();
        ld_issue = 1'b0; ra = 4'd3; rb = 4'd9; #1;
        checkOutput("mid_busy_stall", 64'(stall), 64'h1);
        clr = 1'b0; ld_issue = 1'b1; #1;
        checkOutput("mid_reset_stall", 64'(stall), 64'h0);
        checkOutput("mid_reset_pending", 64'(ld_pending), 64'h0);
        checkOutput("mid_reset_rd_b", 64'(rd_b), 64'h0);
        checkOutput("mid_reset_conflict", 64'(wr_conflict), 64'h0);
        checkOutput("mid_reset_rdy", 64'(ld_issue_rdy), 64'h1);
        applyStimulus();
        ld_issue = 1'b0; clr = 1'b1; #1;
        checkOutput("post_reset_stall", 64'(stall), 64'h0);
        ld_ret_valid = 1'b1; ld_ret_dst = 4'd3; ld_ret_data = 32'h77;
        applyStimulus();
        clearControls();
        checkOutput("late_ret_data", 64'(rd_a), 64'h77);
        checkOutput("late_ret_pending", 64'(ld_pending), 64'h0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
